// File: rtl/memoria_de_dados_multiciclo.sv
// ============================================================================
//  Module      : memoria_de_dados_multiciclo
//  Description : Multicycle byte-addressed data memory with wait states,
//                sub-word access, sign/zero extension and request rejection.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module memoria_de_dados_multiciclo #(
    parameter int ADDR_WIDTH  = 7,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ReadMem,
    input  logic        WriteMem,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    input  logic [31:0] result_ALU,
    input  logic [31:0] Read_data02,
    output logic [31:0] Exit_DataMem,
    output logic        Busy,
    output logic        Done,
    output logic        Error
);

    localparam int         c_depth = 2 ** (ADDR_WIDTH - 2);
    localparam logic [3:0] c_wait  = 4'(WAIT_STATES);

    typedef logic [c_depth-1:0][31:0] mem_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    function automatic mem_t f_mem_init();
        mem_t v;
        for (int i = 0; i < c_depth; i++) begin
            v[i] = 32'(i + 1);
        end
        return v;
    endfunction

    localparam mem_t c_mem_init = f_mem_init();

    // Power-up image only; reset deliberately leaves the array alone.
    mem_t r_mem = c_mem_init;

    state_t                  r_state, w_state_next;
    logic [3:0]              r_count, w_count_next;
    logic [1:0]              r_size;
    logic                    r_unsigned;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [31:0]             r_wdata;
    logic                    r_write;
    logic [31:0]             r_rdata;

    logic                    w_req, w_bad, w_access, w_in_idle;
    logic [1:0]              w_a_size;
    logic                    w_a_unsigned, w_a_write;
    logic [ADDR_WIDTH-1:0]   w_a_addr;
    logic [31:0]             w_a_wdata;
    logic [ADDR_WIDTH-3:0]   w_idx;
    logic [31:0]             w_word, w_rdata_ext, w_wdata_lanes;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic [3:0]              w_be;

    assign w_req     = ReadMem | WriteMem;
    assign w_in_idle = (r_state == S_IDLE);
    assign w_bad     = (ReadMem & WriteMem)
                     | (Size == 2'b11)
                     | ((Size == 2'b01) & result_ALU[0])
                     | ((Size == 2'b10) & (result_ALU[1:0] != 2'b00))
                     | ((result_ALU >> ADDR_WIDTH) != 32'd0);

    // With zero wait states the access happens on the capturing edge itself,
    // so the operands come straight from the ports instead of the capture regs.
    assign w_a_size     = w_in_idle ? Size                         : r_size;
    assign w_a_unsigned = w_in_idle ? Unsigned                     : r_unsigned;
    assign w_a_write    = w_in_idle ? WriteMem                     : r_write;
    assign w_a_addr     = w_in_idle ? result_ALU[ADDR_WIDTH-1:0]   : r_addr;
    assign w_a_wdata    = w_in_idle ? Read_data02                  : r_wdata;

    assign w_idx  = w_a_addr[ADDR_WIDTH-1:2];
    assign w_word = r_mem[w_idx];
    assign w_byte = w_word[{w_a_addr[1:0], 3'b000} +: 8];
    assign w_half = w_a_addr[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_rdata_ext   = w_word;
        w_wdata_lanes = w_a_wdata;
        w_be          = 4'b1111;
        case (w_a_size)
            2'b00: begin
                w_rdata_ext   = w_a_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
                w_wdata_lanes = {4{w_a_wdata[7:0]}};
                w_be          = 4'b0001 << w_a_addr[1:0];
            end
            2'b01: begin
                w_rdata_ext   = w_a_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
                w_wdata_lanes = {2{w_a_wdata[15:0]}};
                w_be          = w_a_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_access     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_bad) begin
                        w_state_next = S_ERR;
                    end else if (c_wait == 4'd0) begin
                        w_state_next = S_RESP;
                        w_access     = 1'b1;
                    end else begin
                        w_state_next = S_WAIT;
                        w_count_next = c_wait;
                    end
                end
            end
            S_WAIT: begin
                // Leave after exactly WAIT_STATES cycles in this state.
                if (r_count <= 4'd1) begin
                    w_state_next = S_RESP;
                    w_count_next = 4'd0;
                    w_access     = 1'b1;
                end else begin
                    w_count_next = r_count - 4'd1;
                end
            end
            S_RESP:  w_state_next = S_IDLE;
            S_ERR:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_count    <= 4'd0;
            r_rdata    <= 32'd0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_write    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            if (w_in_idle && w_req) begin
                r_size     <= Size;
                r_unsigned <= Unsigned;
                r_addr     <= result_ALU[ADDR_WIDTH-1:0];
                r_wdata    <= Read_data02;
                r_write    <= WriteMem;
            end
            if (w_access && !w_a_write) begin
                r_rdata <= w_rdata_ext;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_access && w_a_write) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    r_mem[w_idx][8*k +: 8] <= w_wdata_lanes[8*k +: 8];
                end
            end
        end
    end

    assign Exit_DataMem = r_rdata;
    assign Busy         = (r_state == S_WAIT) || (r_state == S_RESP);
    assign Done         = (r_state == S_RESP) || (r_state == S_ERR);
    assign Error        = (r_state == S_ERR);

endmodule

`default_nettype wire

// File: tb/tb_memoria_de_dados_multiciclo.sv
// ============================================================================
//  Module      : tb_memoria_de_dados_multiciclo
//  Description : Directed self-checking bench for memoria_de_dados_multiciclo
//                (default build and a zero-wait-state build).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memoria_de_dados_multiciclo;

    logic        clk = 1'b0;
    logic        reset;

    logic        a_rd, a_wr, a_uns;
    logic [1:0]  a_sz;
    logic [31:0] a_addr, a_wd, a_q;
    logic        a_busy, a_done, a_err;

    logic        b_rd, b_wr, b_uns;
    logic [1:0]  b_sz;
    logic [31:0] b_addr, b_wd, b_q;
    logic        b_busy, b_done, b_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memoria_de_dados_multiciclo dut (
        .clk(clk), .reset(reset), .ReadMem(a_rd), .WriteMem(a_wr), .Size(a_sz),
        .Unsigned(a_uns), .result_ALU(a_addr), .Read_data02(a_wd),
        .Exit_DataMem(a_q), .Busy(a_busy), .Done(a_done), .Error(a_err)
    );

    memoria_de_dados_multiciclo #(.ADDR_WIDTH(7), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .ReadMem(b_rd), .WriteMem(b_wr), .Size(b_sz),
        .Unsigned(b_uns), .result_ALU(b_addr), .Read_data02(b_wd),
        .Exit_DataMem(b_q), .Busy(b_busy), .Done(b_done), .Error(b_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // One request on the default build; returns negedges until Done (0 = timeout).
    task automatic access_a(input logic rd, input logic wr, input logic [1:0] sz,
                            input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                            output int lat, output int busy_n,
                            output logic [31:0] q, output logic err);
        @(negedge clk);
        a_rd = rd; a_wr = wr; a_sz = sz; a_uns = uns; a_addr = addr; a_wd = wd;
        @(posedge clk);
        #1;
        a_rd = 1'b0; a_wr = 1'b0;
        lat = 0; busy_n = 0; q = 32'd0; err = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (a_busy) busy_n++;
            if (a_done) begin
                lat = n; q = a_q; err = a_err;
                break;
            end
        end
    endtask

    int          lat, bn, dn;
    logic [31:0] q;
    logic        err;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        a_rd = 0; a_wr = 0; a_sz = 2'b10; a_uns = 0; a_addr = 0; a_wd = 0;
        b_rd = 0; b_wr = 0; b_sz = 2'b10; b_uns = 0; b_addr = 0; b_wd = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_q",    a_q,           32'h0);
        check("rst_busy", 32'(a_busy),   32'h0);
        check("rst_done", 32'(a_done),   32'h0);
        check("rst_err",  32'(a_err),    32'h0);

        access_a(1, 0, 2'b10, 0, 32'h0C, 0, lat, bn, q, err);
        check("rd0C_lat",  32'(lat), 32'd3);
        check("rd0C_busy", 32'(bn),  32'd3);
        check("rd0C_q",    q,        32'h00000004);
        check("rd0C_err",  32'(err), 32'h0);

        access_a(0, 1, 2'b00, 0, 32'h05, 32'h00000080, lat, bn, q, err);
        check("sb05_lat", 32'(lat), 32'd3);
        check("sb05_q",   q,        32'h00000004);
        access_a(1, 0, 2'b00, 0, 32'h05, 0, lat, bn, q, err);
        check("lb05_q",   q, 32'hFFFFFF80);
        access_a(1, 0, 2'b00, 1, 32'h05, 0, lat, bn, q, err);
        check("lbu05_q",  q, 32'h00000080);
        access_a(1, 0, 2'b10, 0, 32'h04, 0, lat, bn, q, err);
        check("lw04_q",   q, 32'h00008002);

        access_a(0, 1, 2'b01, 0, 32'h06, 32'hA5A51234, lat, bn, q, err);
        access_a(1, 0, 2'b10, 0, 32'h04, 0, lat, bn, q, err);
        check("lw04b_q",  q, 32'h12348002);
        access_a(0, 1, 2'b01, 0, 32'h0A, 32'h0000BEEF, lat, bn, q, err);
        access_a(1, 0, 2'b01, 0, 32'h0A, 0, lat, bn, q, err);
        check("lh0A_q",   q, 32'hFFFFBEEF);
        access_a(1, 0, 2'b01, 1, 32'h0A, 0, lat, bn, q, err);
        check("lhu0A_q",  q, 32'h0000BEEF);
        access_a(1, 0, 2'b00, 1, 32'h08, 0, lat, bn, q, err);
        check("lbu08_q",  q, 32'h00000003);

        // Rejected requests: one-cycle Done+Error, Exit_DataMem holds 0x03.
        access_a(1, 0, 2'b01, 0, 32'h03, 0, lat, bn, q, err);
        check("eh03_lat", 32'(lat), 32'd1);
        check("eh03_err", 32'(err), 32'h1);
        check("eh03_q",   q,        32'h00000003);
        check("eh03_busy",32'(bn),  32'd0);
        access_a(1, 0, 2'b10, 0, 32'h02, 0, lat, bn, q, err);
        check("ew02_err", 32'(err), 32'h1);
        access_a(0, 1, 2'b11, 0, 32'h14, 32'hFFFFFFFF, lat, bn, q, err);
        check("esz_err",  32'(err), 32'h1);
        access_a(1, 0, 2'b10, 0, 32'h80, 0, lat, bn, q, err);
        check("e80_err",  32'(err), 32'h1);
        check("e80_q",    q,        32'h00000003);
        access_a(1, 1, 2'b10, 0, 32'h00, 32'hFFFFFFFF, lat, bn, q, err);
        check("erw_err",  32'(err), 32'h1);
        @(negedge clk);
        check("err_clr",  32'(a_done), 32'h0);
        access_a(1, 0, 2'b10, 0, 32'h00, 0, lat, bn, q, err);
        check("lw00_q",   q, 32'h00000001);
        access_a(1, 0, 2'b10, 0, 32'h14, 0, lat, bn, q, err);
        check("lw14_q",   q, 32'h00000006);
        access_a(1, 0, 2'b10, 0, 32'h7C, 0, lat, bn, q, err);
        check("lw7C_q",   q, 32'h00000020);

        // Reset during WAIT aborts a pending write.
        @(negedge clk);
        a_wr = 1; a_sz = 2'b10; a_addr = 32'h10; a_wd = 32'hDEADBEEF;
        @(posedge clk);
        #1 a_wr = 0;
        @(negedge clk);
        check("wab_busy", 32'(a_busy), 32'h1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        dn = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (a_done) dn++;
        end
        check("wab_done", 32'(dn), 32'd0);
        check("wab_rstq", a_q,     32'h0);
        access_a(1, 0, 2'b10, 0, 32'h10, 0, lat, bn, q, err);
        check("lw10_q",   q, 32'h00000005);

        // Reset beats a simultaneous request.
        @(negedge clk);
        reset = 1'b1; a_rd = 1; a_addr = 32'h0C;
        @(posedge clk);
        #1 begin reset = 1'b0; a_rd = 0; end
        @(negedge clk);
        check("rr_busy",  32'(a_busy), 32'h0);
        @(negedge clk);
        check("rr_done",  32'(a_done), 32'h0);

        // Zero-wait build: held read request, Done every second cycle.
        @(negedge clk);
        b_rd = 1; b_sz = 2'b10; b_addr = 32'h00;
        @(negedge clk);
        check("z_done1", 32'(b_done), 32'h1);
        check("z_q1",    b_q,         32'h00000001);
        check("z_err1",  32'(b_err),  32'h0);
        b_addr = 32'h04;
        @(negedge clk);
        check("z_gap",   32'(b_done), 32'h0);
        @(negedge clk);
        check("z_done2", 32'(b_done), 32'h1);
        check("z_q2",    b_q,         32'h00000002);
        b_rd = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
